// File: rtl/jtopl_modcnt.sv
// Modulo counter: counts 0..limit on enabled cycles and flags the wrap with a
// registered one-clock terminal pulse. Synchronous clear has priority over enable.
module jtopl_modcnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] limit,
    output logic [W-1:0] cnt,
    output logic         tc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            tc  <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            tc  <= 1'b0;
        end else if (en) begin
            if (cnt == limit) begin
                cnt <= '0;
                tc  <= 1'b1;
            end else begin
                cnt <= cnt + W'(1);
                tc  <= 1'b0;
            end
        end else begin
            tc <= 1'b0;
        end
    end

endmodule

// File: rtl/jtopl_timebase.sv
// Time base: prescales cen by (div+1) into cen_div, walks a slot index
// 0..SLOTN-1 on each cen_div and flags the period following the last slot.
module jtopl_timebase #(
    parameter int DIVW  = 4,
    parameter int SLOTN = 19,
    parameter int SW    = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cen,
    input  logic [DIVW-1:0] div,
    input  logic            sync,
    output logic            cen_div,
    output logic [SW-1:0]   slot,
    output logic            zero
);

    localparam logic [SW-1:0] SLOT_LAST = SW'(SLOTN - 1);

    generate
        if ((1 << SW) < SLOTN) begin : g_bad_sw
            $error("jtopl_timebase: SW too narrow for SLOTN");
        end
    endgenerate

    logic [DIVW-1:0] pcnt;
    logic [DIVW-1:0] div_act;
    logic            terminal;
    logic            slot_tc;
    logic            zero_hold;

    assign terminal = cen && (pcnt == div_act);

    // The ratio is only sampled at a period boundary so the running period keeps its length
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_act <= '1;
        end else if (sync || terminal) begin
            div_act <= div;
        end
    end

    jtopl_modcnt #(
        .W (DIVW)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .en    (cen),
        .clr   (sync),
        .limit (div_act),
        .cnt   (pcnt),
        .tc    (cen_div)
    );

    jtopl_modcnt #(
        .W (SW)
    ) u_slot (
        .clk   (clk),
        .rst   (rst),
        .en    (cen_div),
        .clr   (sync),
        .limit (SLOT_LAST),
        .cnt   (slot),
        .tc    (slot_tc)
    );

    // slot_tc marks the first clock after the last slot; zero_hold stretches it to the next cen_div
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_hold <= 1'b0;
        end else if (sync || cen_div) begin
            zero_hold <= 1'b0;
        end else if (slot_tc) begin
            zero_hold <= 1'b1;
        end
    end

    assign zero = slot_tc | zero_hold;

endmodule

// File: tb/tb_jtopl_timebase.sv
// Directed testbench for jtopl_timebase: a per-clock vector table plus
// hand-written sequences for long periods, sync collisions and async reset.
module tb_jtopl_timebase;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cen = 1'b0;
    logic [3:0] div = 4'd15;
    logic       sync = 1'b0;
    logic       cen_div;
    logic [4:0] slot;
    logic       zero;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic       cen;
        logic [3:0] div;
        logic       sync;
        logic       exp_cd;
        logic [4:0] exp_slot;
        logic       exp_zero;
    } vec_t;

    vec_t vecs[18];

    jtopl_timebase #(
        .DIVW  (4),
        .SLOTN (19),
        .SW    (5)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .cen     (cen),
        .div     (div),
        .sync    (sync),
        .cen_div (cen_div),
        .slot    (slot),
        .zero    (zero)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input vec_t v);
        cen  = v.cen;
        div  = v.div;
        sync = v.sync;
        step();
    endtask

    // Steps until cen_div is seen; n is the number of edges taken
    task automatic wait_pulse(input int limit, output int n, output bit ok);
        n = 0;
        do begin
            step();
            n++;
        end while (cen_div !== 1'b1 && n < limit);
        ok = (cen_div === 1'b1);
    endtask

    initial begin
        int n;
        bit ok;
        int gap;

        vecs[0]  = '{1'b0, 4'd1, 1'b1, 1'b0, 5'd0, 1'b0};
        vecs[1]  = '{1'b1, 4'd1, 1'b0, 1'b0, 5'd0, 1'b0};
        vecs[2]  = '{1'b0, 4'd1, 1'b0, 1'b0, 5'd0, 1'b0};
        vecs[3]  = '{1'b0, 4'd1, 1'b0, 1'b0, 5'd0, 1'b0};
        vecs[4]  = '{1'b1, 4'd1, 1'b0, 1'b1, 5'd0, 1'b0};
        vecs[5]  = '{1'b0, 4'd1, 1'b0, 1'b0, 5'd1, 1'b0};
        vecs[6]  = '{1'b0, 4'd1, 1'b0, 1'b0, 5'd1, 1'b0};
        vecs[7]  = '{1'b1, 4'd1, 1'b0, 1'b0, 5'd1, 1'b0};
        vecs[8]  = '{1'b0, 4'd1, 1'b0, 1'b0, 5'd1, 1'b0};
        vecs[9]  = '{1'b0, 4'd1, 1'b0, 1'b0, 5'd1, 1'b0};
        vecs[10] = '{1'b1, 4'd1, 1'b0, 1'b1, 5'd1, 1'b0};
        vecs[11] = '{1'b0, 4'd1, 1'b0, 1'b0, 5'd2, 1'b0};
        vecs[12] = '{1'b1, 4'd0, 1'b1, 1'b0, 5'd0, 1'b0};
        vecs[13] = '{1'b1, 4'd0, 1'b0, 1'b1, 5'd0, 1'b0};
        vecs[14] = '{1'b1, 4'd0, 1'b0, 1'b1, 5'd1, 1'b0};
        vecs[15] = '{1'b1, 4'd0, 1'b0, 1'b1, 5'd2, 1'b0};
        vecs[16] = '{1'b0, 4'd0, 1'b0, 1'b0, 5'd3, 1'b0};
        vecs[17] = '{1'b1, 4'd0, 1'b0, 1'b1, 5'd3, 1'b0};

        // Reset state, before any clock edge
        #2;
        check_output("reset_cen_div", 32'(cen_div), 32'd0);
        check_output("reset_slot", 32'(slot), 32'd0);
        check_output("reset_zero", 32'(zero), 32'd0);
        #1;
        rst = 1'b0;
        step();

        // Vector table: div=1 with cen 1-in-3, then sync into div=0
        for (int i = 0; i < 18; i++) begin
            apply_stimulus(vecs[i]);
            check_output($sformatf("vec%0d_cen_div", i), 32'(cen_div), 32'(vecs[i].exp_cd));
            check_output($sformatf("vec%0d_slot", i), 32'(slot), 32'(vecs[i].exp_slot));
            check_output($sformatf("vec%0d_zero", i), 32'(zero), 32'(vecs[i].exp_zero));
        end

        // div=0, continuous cen: pulse every clock, slot wraps after 19
        cen = 1'b1; div = 4'd0; sync = 1'b1;
        step();
        sync = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            check_output($sformatf("div0_k%0d_cen_div", k), 32'(cen_div), 32'd1);
            check_output($sformatf("div0_k%0d_slot", k), 32'(slot), 32'((k - 1) % 19));
            check_output($sformatf("div0_k%0d_zero", k), 32'(zero), 32'(k == 20));
        end

        // Asynchronous reset while cen_div and zero are both high
        rst = 1'b1;
        #1;
        check_output("async_rst_cen_div", 32'(cen_div), 32'd0);
        check_output("async_rst_zero", 32'(zero), 32'd0);
        check_output("async_rst_slot", 32'(slot), 32'd0);
        div = 4'd3; cen = 1'b1;
        #1;
        rst = 1'b0;

        // After reset the first period still uses the all-ones ratio
        wait_pulse(40, n, ok);
        check_output("post_rst_first_ok", 32'(ok), 32'd1);
        check_output("post_rst_first_gap", 32'(n), 32'd16);
        wait_pulse(40, n, ok);
        check_output("post_rst_second_ok", 32'(ok), 32'd1);
        check_output("post_rst_second_gap", 32'(n), 32'd4);

        // div=15, continuous cen from reset
        rst = 1'b1; div = 4'd15; cen = 1'b1;
        #2;
        rst = 1'b0;
        gap = 16;
        for (int p = 0; p <= 20; p++) begin
            wait_pulse(40, n, ok);
            check_output($sformatf("div15_p%0d_ok", p), 32'(ok), 32'd1);
            check_output($sformatf("div15_p%0d_gap", p), 32'(n), 32'(gap));
            check_output($sformatf("div15_p%0d_slot", p), 32'(slot), 32'(p % 19));
            check_output($sformatf("div15_p%0d_zero", p), 32'(zero), 32'(p == 19));
            gap = 16;
            if (p == 18) begin
                step();
                check_output("div15_after18_zero", 32'(zero), 32'd1);
                check_output("div15_after18_cen_div", 32'(cen_div), 32'd0);
                gap = 15;
            end
        end

        // div changed 15->3 mid-period: running period completes at 16
        div = 4'd15; sync = 1'b1;
        step();
        sync = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            check_output($sformatf("divchg_k%0d_cen_div", k), 32'(cen_div), 32'd0);
        end
        div = 4'd3;
        wait_pulse(40, n, ok);
        check_output("divchg_first_gap", 32'(n), 32'd11);
        wait_pulse(40, n, ok);
        check_output("divchg_second_gap", 32'(n), 32'd4);
        wait_pulse(40, n, ok);
        check_output("divchg_third_gap", 32'(n), 32'd4);

        // sync on a terminal cycle at slot 18 suppresses the pulse
        div = 4'd3; sync = 1'b1;
        step();
        sync = 1'b0;
        for (int k = 1; k <= 75; k++) step();
        check_output("sync_pre_slot", 32'(slot), 32'd18);
        sync = 1'b1;
        step();
        sync = 1'b0;
        check_output("sync_cen_div", 32'(cen_div), 32'd0);
        check_output("sync_slot", 32'(slot), 32'd0);
        check_output("sync_zero", 32'(zero), 32'd0);
        wait_pulse(40, n, ok);
        check_output("sync_next_ok", 32'(ok), 32'd1);
        check_output("sync_next_gap", 32'(n), 32'd4);
        check_output("sync_next_slot", 32'(slot), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
